// File: rtl/image_mem_streamer_if.sv
// image_mem_streamer_if: bus bundle between the frame streamer, the image RAM
// read port and the downstream pixel consumer.
//   start/done          : frame request and completion pulse
//   mem_addr/mem_data   : RAM read address and combinational read data
//   mem_busy            : streamer owns the RAM address bus
//   pix_data/valid/ready/last (+pix_eol with STREAMER_EOL_EN) : pixel stream
// Optional macro: STREAMER_EOL_EN adds pix_eol.
interface image_mem_streamer_if #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
);
  logic                     start;
  logic                     done;
  logic [RAM_ADDR_BITS-1:0] mem_addr;
  logic [RAM_WIDTH-1:0]     mem_data;
  logic                     mem_busy;
  logic [RAM_WIDTH-1:0]     pix_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     pix_last;
`ifdef STREAMER_EOL_EN
  logic                     pix_eol;
`endif

  modport master (
    input  start, mem_data, pix_ready,
    output done, mem_addr, mem_busy, pix_data, pix_valid, pix_last
`ifdef STREAMER_EOL_EN
    , pix_eol
`endif
  );

  modport slave (
    output start, mem_data, pix_ready,
    input  done, mem_addr, mem_busy, pix_data, pix_valid, pix_last
`ifdef STREAMER_EOL_EN
    , pix_eol
`endif
  );
endinterface

// File: rtl/image_mem_streamer.sv
// image_mem_streamer: read-side master of the single-port image RAM. On a
// start pulse it scans addresses 0..NUM_PIXELS-1 and emits them as a
// valid/ready pixel stream, holding mem_busy while it owns the address bus.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : image_mem_streamer_if.master (start/done, RAM read port, pixel stream)
// Optional macro: STREAMER_EOL_EN adds a line counter, the LINE_WIDTH
// parameter and the pix_eol output.
// All outputs are registered.
module image_mem_streamer #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10,
  parameter int NUM_PIXELS    = 1024
`ifdef STREAMER_EOL_EN
  , parameter int LINE_WIDTH  = 32
`endif
) (
  input logic                  clk,
  input logic                  reset,
  image_mem_streamer_if.master bus
);

  // Terminal address is a compare, so a full 2**RAM_ADDR_BITS frame never
  // depends on counter wrap.
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_WIDTH-1:0]     data_q;
  logic                     valid_q, last_q, done_q, busy_q;

  // Output register may take a new pixel when empty or being drained.
  logic load;
  logic at_last;
  assign load    = !valid_q || bus.pix_ready;
  assign at_last = (addr_q == LAST_ADDR);

`ifdef STREAMER_EOL_EN
  localparam int LW_BITS = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [LW_BITS-1:0] LINE_LAST = LW_BITS'(LINE_WIDTH - 1);
  logic [LW_BITS-1:0] line_q;
  logic               eol_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef STREAMER_EOL_EN
      line_q  <= '0;
      eol_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            addr_q  <= '0;
            busy_q  <= 1'b1;
`ifdef STREAMER_EOL_EN
            line_q  <= '0;
`endif
          end
        end
        RUN: begin
          if (load) begin
            data_q  <= bus.mem_data;
            valid_q <= 1'b1;
            last_q  <= at_last;
            if (at_last) begin
              state_q <= DRAIN;
              addr_q  <= '0;
            end else begin
              addr_q  <= addr_q + 1'b1;
            end
`ifdef STREAMER_EOL_EN
            eol_q  <= at_last || (line_q == LINE_LAST);
            line_q <= (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
`endif
          end
        end
        DRAIN: begin
          // Final pixel is held until the consumer takes it.
          if (bus.pix_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef STREAMER_EOL_EN
            eol_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_busy  = busy_q;
  assign bus.pix_data  = data_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_last  = last_q;
  assign bus.done      = done_q;
`ifdef STREAMER_EOL_EN
  assign bus.pix_eol   = eol_q;
`endif

endmodule

// File: tb/tb_image_mem_streamer.sv
// tb_image_mem_streamer: directed bench for image_mem_streamer.
// u_dut16 streams a 16-pixel frame from a RAM with image[i]=i; u_dut1 streams
// a 1-pixel frame (A5). With STREAMER_EOL_EN, u_dut10 checks end-of-line flags.
module tb_image_mem_streamer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  image_mem_streamer_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) if16 ();
  image_mem_streamer_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) if1 ();

  assign if16.mem_data = if16.mem_addr[7:0];
  assign if1.mem_data  = (if1.mem_addr == 10'd0) ? 8'hA5 : 8'h00;

  image_mem_streamer #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10), .NUM_PIXELS(16))
    u_dut16 (.clk(clk), .reset(reset), .bus(if16));
  image_mem_streamer #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10), .NUM_PIXELS(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));

`ifdef STREAMER_EOL_EN
  image_mem_streamer_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) if10 ();
  assign if10.mem_data = if10.mem_addr[7:0];
  image_mem_streamer #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10), .NUM_PIXELS(10), .LINE_WIDTH(4))
    u_dut10 (.clk(clk), .reset(reset), .bus(if10));
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame on u_dut16 with pix_ready held high.
  task automatic run_frame(input string p);
    if16.pix_ready = 1'b1;
    if16.start     = 1'b1;
    tick();
    if16.start = 1'b0;
    chk({p, "_addr0"}, 32'({if16.mem_addr, if16.mem_busy, if16.pix_valid}),
        32'({10'd0, 1'b1, 1'b0}));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({p, "_pix"}, 32'({if16.pix_valid, if16.pix_last, if16.pix_data}),
          32'({1'b1, (i == 15), 8'(i)}));
    end
    tick();
    chk({p, "_done"}, 32'({if16.done, if16.pix_valid, if16.mem_busy}), 32'b100);
    tick();
    chk({p, "_done_clr"}, 32'(if16.done), 32'd0);
  endtask

  initial begin
    int       exp_i;
    int       n_acc;
    int       n_done;
    logic     hold_chk;
    logic [7:0] hold_v;
    logic     seen_done;
    logic [9:0] eol_exp;

    reset = 1'b1;
    if16.start = 1'b0; if16.pix_ready = 1'b0;
    if1.start  = 1'b0; if1.pix_ready  = 1'b0;
`ifdef STREAMER_EOL_EN
    if10.start = 1'b0; if10.pix_ready = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", 32'({if16.mem_addr, if16.pix_data, if16.pix_valid, if16.pix_last,
                            if16.done, if16.mem_busy}), 32'd0);

    // 1: full-rate frame
    run_frame("t1");

    // 2: stalled frame, ready pattern 1,0,0
    exp_i = 0; hold_chk = 1'b0; hold_v = '0; seen_done = 1'b0;
    if16.pix_ready = 1'b0;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick();
      if (hold_chk) chk("t2_hold", 32'(if16.pix_data), 32'(hold_v));
      if (if16.done) seen_done = 1'b1;
      if16.pix_ready = (c % 3 == 0);
      hold_chk = if16.pix_valid && !if16.pix_ready;
      hold_v   = if16.pix_data;
      if (if16.pix_valid && if16.pix_ready) begin
        chk("t2_pix", 32'(if16.pix_data), 32'(exp_i));
        chk("t2_last", 32'(if16.pix_last), 32'(exp_i == 15));
        exp_i++;
      end
    end
    chk("t2_count", 32'(exp_i), 32'd16);
    chk("t2_done", 32'(seen_done), 32'd1);

    // 3: reset while the 6th pixel is being accepted
    if16.pix_ready = 1'b1;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3_pre", 32'(if16.pix_data), 32'(k));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_reset", 32'({if16.mem_addr, if16.pix_data, if16.pix_valid, if16.pix_last,
                         if16.done, if16.mem_busy}), 32'd0);
    tick(); tick();
    chk("t3_idle", 32'({if16.pix_valid, if16.mem_busy}), 32'd0);
    run_frame("t3");

    // 4: start during RUN ignored, start on done cycle chains frame 2
    n_acc = 0; n_done = 0;
    if16.pix_ready = 1'b1;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    for (int c = 0; c < 100 && n_done < 2; c++) begin
      tick();
      if16.start = (c == 5) || (if16.done && n_done == 0);
      if (if16.done) n_done++;
      if (if16.pix_valid && if16.pix_ready) begin
        chk("t4_pix", 32'(if16.pix_data), 32'(n_acc % 16));
        n_acc++;
      end
    end
    if16.start = 1'b0;
    chk("t4_count", 32'(n_acc), 32'd32);
    chk("t4_dones", 32'(n_done), 32'd2);
    tick(); tick();
    chk("t4_idle", 32'({if16.pix_valid, if16.mem_busy}), 32'd0);

    // 5: single-pixel frame with 3 stalled cycles
    if1.pix_ready = 1'b0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_pix", 32'({if1.pix_valid, if1.pix_last, if1.pix_data, if1.done}),
          32'({1'b1, 1'b1, 8'hA5, 1'b0}));
      if (c == 3) if1.pix_ready = 1'b1;
    end
    tick();
    chk("t5_done", 32'({if1.done, if1.pix_valid, if1.mem_busy}), 32'b100);
    tick();
    chk("t5_done_clr", 32'(if1.done), 32'd0);

`ifdef STREAMER_EOL_EN
    // 6: LINE_WIDTH=4, 10 pixels -> eol on 3, 7, 9
    eol_exp = 10'b10_1000_1000;
    if10.pix_ready = 1'b1;
    if10.start = 1'b1;
    tick();
    if10.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_eol", 32'({if10.pix_data, if10.pix_eol}), 32'({8'(i), eol_exp[i]}));
    end
    tick();
    chk("t6_done", 32'(if10.done), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/image_mem_streamer.md
Name: image_mem_streamer

Overview:
- Read-side master for the single-port image memory: scans a frame out, address 0 to NUM_PIXELS-1, as a pixel stream with a valid/ready handshake.
- Drives the memory address and reads its asynchronous (combinational) data output; never writes.
- Sits between the image RAM and downstream consumers (FIFO, display/serial output).
- Asserts mem_busy while it owns the address bus so the write path can be muxed off.

Parameters:
RAM_WIDTH, 8, pixel/data width in bits
RAM_ADDR_BITS, 10, memory address width
NUM_PIXELS, 1024, pixels per frame; legal range 1..2**RAM_ADDR_BITS
LINE_WIDTH, 32, pixels per image line; used only with STREAMER_EOL_EN

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to stream one frame
mem_addr  out  RAM_ADDR_BITS  address to image memory
mem_data  in  RAM_WIDTH  combinational read data from image memory (valid same cycle as mem_addr)
mem_busy  out  1  high while streamer owns the memory address
pix_data  out  RAM_WIDTH  pixel value
pix_valid  out  1  pix_data valid
pix_ready  in  1  consumer accepts pixel when pix_valid && pix_ready at clk edge
pix_last  out  1  high with the final pixel of the frame
done  out  1  one-cycle pulse after final pixel accepted
pix_eol  out  1  end-of-line flag (only with STREAMER_EOL_EN)

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high.
- Reset (any cycle, including mid-frame): state=IDLE; mem_addr=0, pix_data=0, pix_valid=0, pix_last=0, pix_eol=0, done=0, mem_busy=0. An in-flight frame is abandoned, not resumed.
- Every output is registered.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 -> RUN, mem_addr<=0, mem_busy<=1. start is ignored in RUN/DRAIN.
- RUN, load condition L = (!pix_valid || pix_ready).
  - On L: pix_data<=mem_data, pix_valid<=1, pix_last<=(mem_addr==NUM_PIXELS-1), mem_addr<=mem_addr+1.
  - Loading address NUM_PIXELS-1 -> DRAIN; mem_addr<=0 there, no increment past the end.
  - If !L, all outputs hold; pix_data must not change while pix_valid && !pix_ready.
- Throughput: 1 pixel/clk with pix_ready held high.
- Latency: start sampled at edge N -> mem_addr=0 after N; pixel 0 valid after edge N+1.
- DRAIN: hold the last pixel until accepted.
  - On pix_ready: pix_valid<=0, pix_last<=0, mem_busy<=0, done<=1, -> IDLE.
  - done clears on the next cycle.
- NUM_PIXELS=1: RUN loads a single pixel with pix_last=1, then -> DRAIN.
- Address counter is RAM_ADDR_BITS wide. NUM_PIXELS=2**RAM_ADDR_BITS terminates by compare, not by wrap.
- start arriving on the same cycle done is high: state is already IDLE, so it is accepted; back-to-back frames are allowed.

Optional Feature:
- Macro: STREAMER_EOL_EN
- Defined:
  - Line-position counter (0..LINE_WIDTH-1) advances on each load.
  - pix_eol=1 with every pixel whose frame index mod LINE_WIDTH == LINE_WIDTH-1, and also with the final pixel.
  - Counter resets with reset and at frame start.
  - pix_eol follows the same hold rules as pix_data.
- Undefined: port pix_eol is absent and no line counter is built.

Test Plan:
1. Memory preloaded image[i]=i[7:0], NUM_PIXELS=16, pix_ready=1, start pulse -> pixels 0..15 on 16 consecutive cycles, first pixel one cycle after mem_addr=0; pix_last only with value 15; done one cycle later; mem_busy falls with done.
2. Same frame, pix_ready toggling 1,0,0,1,... -> every pixel 0..15 delivered exactly once, in order; pix_data stable while stalled; no duplicates or drops.
3. Reset asserted on the 6th accepted pixel -> next cycle all outputs 0, state IDLE; a fresh start restreams from pixel 0.
4. start pulsed during RUN, then again on the done cycle -> first pulse ignored; second pulse starts frame 2 immediately, giving 32 pixels total.
5. NUM_PIXELS=1, image[0]=8'hA5, pix_ready=0 for 3 cycles then 1 -> single pixel A5 with pix_last=1 held 4 cycles; done pulse after acceptance.
6. STREAMER_EOL_EN, LINE_WIDTH=4, NUM_PIXELS=10 -> pix_eol on pixel indices 3, 7, 9.
